// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared FP32 multiplier widths, flag indices and result word type
package fpmul_pkg;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam int FP32_W = 1 + EXP_W + FRAC_W;
    localparam int FLAG_UNF = 0;
    localparam int FLAG_OVF = 1;
    typedef struct packed {
        logic ovf;
        logic unf;
        logic [FP32_W-1:0] data;
    } fp32_result_t;
endpackage

// File: rtl/fpmul_sat_cnt.sv
// fpmul_sat_cnt: event counter that holds at its maximum value
module fpmul_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    logic [CNT_W-1:0] q_q, q_d;
    always_comb q_d = (inc && q_q != '1) ? q_q + CNT_W'(1) : q_q;
    always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
    assign q = q_q;
endmodule

// File: rtl/fpmul_result_buffer.sv
// fpmul_result_buffer: fall-through FIFO for FP32 products with sticky flags and event counters
module fpmul_result_buffer
    import fpmul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_data,
    input  logic              in_underflow,
    input  logic              in_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_data,
    output logic [1:0]        out_flags,
    input  logic              flush,
    input  logic              clr_sticky,
    output logic              sticky_ovf,
    output logic              sticky_unf,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [CNT_W-1:0]  unf_cnt,
    output logic [PW:0]       count
);
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0] count_q, count_d;
    logic sticky_ovf_q, sticky_ovf_d, sticky_unf_q, sticky_unf_d;
    logic push, pop;
    fp32_result_t mem_q [DEPTH];
    fp32_result_t mem_d [DEPTH];
    fp32_result_t head;
    always_comb begin
        in_ready = count_q != (PW+1)'(DEPTH);
        out_valid = count_q != '0;
        push = in_valid && in_ready;
        pop = out_valid && out_ready;
        head = out_valid ? mem_q[rd_q] : '0;
        out_data = head.data;
        out_flags = '0;
        out_flags[FLAG_OVF] = head.ovf;
        out_flags[FLAG_UNF] = head.unf;
        mem_d = mem_q;
        if (push) mem_d[wr_q] = '{ovf: in_overflow, unf: in_underflow, data: in_data};
        wr_d = flush ? '0 : wr_q + PW'(push);
        rd_d = flush ? '0 : rd_q + PW'(pop);
        count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
        // a flag raised this cycle beats a simultaneous clear
        sticky_ovf_d = (push && in_overflow) || (sticky_ovf_q && !clr_sticky);
        sticky_unf_d = (push && in_underflow) || (sticky_unf_q && !clr_sticky);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    fpmul_sat_cnt #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk(clk), .rst(rst), .inc(push && in_overflow), .q(ovf_cnt)
    );
    fpmul_sat_cnt #(.CNT_W(CNT_W)) u_unf_cnt (
        .clk(clk), .rst(rst), .inc(push && in_underflow), .q(unf_cnt)
    );
    assign sticky_ovf = sticky_ovf_q;
    assign sticky_unf = sticky_unf_q;
    assign count = count_q;
endmodule

// File: tb/tb_fpmul_result_buffer.sv
// tb_fpmul_result_buffer: directed vectors with a queue scoreboard and decoupled output monitor
module tb_fpmul_result_buffer;
    logic clk = 1'b0;
    logic rst, in_valid, in_underflow, in_overflow, out_ready, flush, clr_sticky;
    logic [31:0] in_data;
    logic in_ready, out_valid, sticky_ovf, sticky_unf;
    logic [31:0] out_data;
    logic [1:0] out_flags;
    logic [7:0] ovf_cnt, unf_cnt;
    logic [2:0] count;
    logic in_ready2, out_valid2, sticky_ovf2, sticky_unf2;
    logic [31:0] out_data2;
    logic [1:0] out_flags2;
    logic [1:0] ovf_cnt2, unf_cnt2;
    logic [2:0] count2;
    int compared = 0;
    int mismatched = 0;
    int m_cnt = 0;
    logic [33:0] exp_q [$];

    fpmul_result_buffer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_underflow(in_underflow), .in_overflow(in_overflow), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags), .flush(flush),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
        .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .count(count)
    );
    fpmul_result_buffer #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_underflow(in_underflow), .in_overflow(in_overflow), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_flags(out_flags2), .flush(flush),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf2), .sticky_unf(sticky_unf2),
        .ovf_cnt(ovf_cnt2), .unf_cnt(unf_cnt2), .count(count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic ovf, input logic unf);
        in_valid = 1'b1;
        in_data = d;
        in_overflow = ovf;
        in_underflow = unf;
        cyc();
        in_valid = 1'b0;
        in_overflow = 1'b0;
        in_underflow = 1'b0;
    endtask

    // reference occupancy: decides which pushes the scoreboard expects to see again
    always @(posedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
            m_cnt <= 0;
        end else begin
            if (in_valid && m_cnt < 4) exp_q.push_back({in_overflow, in_underflow, in_data});
            m_cnt <= m_cnt + ((in_valid && m_cnt < 4) ? 1 : 0) - ((out_ready && m_cnt > 0) ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL head: got %0h with no entry expected", {out_flags, out_data});
            end else begin
                chk("head", {out_flags, out_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        {in_valid, in_underflow, in_overflow, out_ready, flush, clr_sticky} = '0;
        in_data = '0;
        cyc(2);
        rst = 1'b0;
        chk("rst_count", 34'(count), 34'd0);
        chk("rst_out_valid", 34'(out_valid), 34'd0);
        chk("rst_in_ready", 34'(in_ready), 34'd1);
        chk("rst_out_word", {out_flags, out_data}, 34'd0);
        chk("rst_status", {sticky_ovf, sticky_unf, ovf_cnt, unf_cnt}, 34'd0);

        push(32'h40400000, 1'b0, 1'b0);
        chk("t1_out_valid", 34'(out_valid), 34'd1);
        chk("t1_out_data", 34'(out_data), 34'h40400000);
        chk("t1_out_flags", 34'(out_flags), 34'd0);
        chk("t1_count", 34'(count), 34'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t1_drained", 34'(count), 34'd0);

        push(32'hA0000000, 1'b0, 1'b0);
        push(32'hA1000000, 1'b0, 1'b0);
        push(32'hA2000000, 1'b0, 1'b0);
        push(32'hA3000000, 1'b0, 1'b0);
        chk("t2_count_full", 34'(count), 34'd4);
        chk("t2_in_ready", 34'(in_ready), 34'd0);
        push(32'hDEADBEEF, 1'b0, 1'b0);
        chk("t2_fifth_ignored", 34'(count), 34'd4);
        out_ready = 1'b1;
        cyc(4);
        out_ready = 1'b0;
        chk("t2_empty", 34'(count), 34'd0);

        push(32'hB0000000, 1'b0, 1'b0);
        push(32'hB1000000, 1'b0, 1'b0);
        push(32'hB2000000, 1'b0, 1'b0);
        push(32'hB3000000, 1'b0, 1'b0);
        out_ready = 1'b1;
        push(32'hBADBAD00, 1'b0, 1'b0);
        chk("t3_count", 34'(count), 34'd3);
        chk("t3_in_ready", 34'(in_ready), 34'd1);
        cyc(3);
        out_ready = 1'b0;
        chk("t3_empty", 34'(count), 34'd0);

        push(32'h0, 1'b1, 1'b0);
        chk("t4_sticky_set", 34'(sticky_ovf), 34'd1);
        chk("t4_ovf_cnt1", 34'(ovf_cnt), 34'd1);
        clr_sticky = 1'b1;
        cyc();
        clr_sticky = 1'b0;
        chk("t4_sticky_clr", 34'(sticky_ovf), 34'd0);
        chk("t4_ovf_cnt_kept", 34'(ovf_cnt), 34'd1);
        clr_sticky = 1'b1;
        push(32'h0, 1'b1, 1'b0);
        clr_sticky = 1'b0;
        chk("t4_set_wins", 34'(sticky_ovf), 34'd1);
        chk("t4_ovf_cnt2", 34'(ovf_cnt), 34'd2);
        out_ready = 1'b1;
        cyc(2);

        repeat (5) push(32'h0, 1'b0, 1'b1);
        cyc(2);
        out_ready = 1'b0;
        chk("t5_unf_cnt_sat", 34'(unf_cnt2), 34'd3);
        chk("t5_sticky_unf_sat", 34'(sticky_unf2), 34'd1);
        chk("t5_unf_cnt_wide", 34'(unf_cnt), 34'd5);
        chk("t5_sticky_unf", 34'(sticky_unf), 34'd1);
        push(32'h0, 1'b1, 1'b1);
        chk("t5_both_ovf", 34'(ovf_cnt), 34'd3);
        chk("t5_both_unf", 34'(unf_cnt), 34'd6);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        push(32'hC1000000, 1'b0, 1'b0);
        push(32'hC2000000, 1'b0, 1'b0);
        chk("t6_count_pre", 34'(count), 34'd2);
        flush = 1'b1;
        push(32'hEEEEEEEE, 1'b0, 1'b0);
        flush = 1'b0;
        chk("t6_flush_count", 34'(count), 34'd0);
        chk("t6_flush_valid", 34'(out_valid), 34'd0);
        push(32'hC0000000, 1'b0, 1'b0);
        chk("t6_after_data", 34'(out_data), 34'hC0000000);
        chk("t6_after_count", 34'(count), 34'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("scoreboard_empty", 34'(exp_q.size()), 34'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
